uart_frame_ctrl: RTL and testbench
==================================

# uart_frame_ctrl

Command-frame controller that sits directly behind the UART receiver in the loopback/command path. It consumes received bytes (`rx_data` qualified by `rx_done`) and parses framed write commands: header, address, length, payload, checksum. Payload is held in a local buffer and committed to a register-write port only after the checksum matches. Malformed, corrupt or stalled frames are discarded and flagged.

## Interface
- `HEADER`, 8'hA5: start-of-frame byte.
- `MAX_LEN`, 8: maximum payload bytes; buffer depth.
- `TIMEOUT_CYCLES`, 32'd4340: inter-byte timeout in clk cycles (10 bit times at 115200 baud / 50 MHz).

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `rx_data`, input, 8: received byte from the UART receiver.
- `rx_done`, input, 1: byte-complete indication from the receiver. Treated as a level; only its rising edge is used.
- `wr_en`, output, 1: register write strobe.
- `wr_addr`, output, 8: write address.
- `wr_data`, output, 8: write data.
- `busy`, output, 1: high in any state except IDLE.
- `frame_ok`, output, 1: one-cycle pulse after a frame commits successfully.
- `frame_err`, output, 1: one-cycle pulse when a frame is dropped.
- `err_code`, output, 2: cause of the last error. 01 = bad length, 10 = checksum mismatch, 11 = timeout. Holds its value until the next error.

## Operation
- Byte acceptance:
  - `rx_done` is registered once.
  - A byte is accepted when `rx_done` is 1 and its registered copy is 0.
  - `rx_data` is sampled on that same cycle.
- FSM states: IDLE, ADDR, LEN, DATA, CSUM, COMMIT.
- IDLE: an accepted byte equal to `HEADER` moves to ADDR. Any other byte is ignored.
- ADDR: latch the byte as base address; the running sum starts at that value; move to LEN.
- LEN:
  - If the byte is 0 or greater than `MAX_LEN`: pulse `frame_err`, set `err_code`=01, go to IDLE.
  - Otherwise latch the length, add it to the sum, clear the index, go to DATA.
- DATA:
  - Store the byte at buffer[index], add it to the sum, increment the index.
  - When index reaches length, go to CSUM.
- CSUM:
  - If the byte equals the sum (8-bit, mod 256), go to COMMIT.
  - Otherwise pulse `frame_err`, set `err_code`=10, go to IDLE.
- COMMIT:
  - One write per cycle for i = 0..len-1: `wr_en`=1, `wr_addr`=(base+i) mod 256, `wr_data`=buffer[i].
  - The cycle after the last write: pulse `frame_ok`, return to IDLE.
  - Accepted bytes in COMMIT are ignored. COMMIT is at most 8 cycles, far shorter than one byte time.
- Timeout:
  - The counter runs in ADDR, LEN, DATA and CSUM, and is cleared on every accepted byte and in IDLE/COMMIT.
  - When it reaches `TIMEOUT_CYCLES`: pulse `frame_err`, set `err_code`=11, go to IDLE.
  - If a byte is accepted on the same cycle as the timeout, the byte wins and the counter clears.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. Buffer contents are don't-care.
- Reset mid-frame or mid-COMMIT aborts immediately. No further `wr_en`, no pulse is issued.
- Latency, last accepted byte to first `wr_en`: 1 cycle (CSUM to COMMIT transition).
- `wr_en` is high for exactly len consecutive cycles; `frame_ok` follows 1 cycle after the last write.
- `frame_err` is asserted the cycle after the offending byte is accepted, or the cycle after the timeout.
- `err_code` updates on the same edge that asserts `frame_err`.
- `wr_addr` wraps 8'hFF to 8'h00. The sum is 8-bit and drops the carry.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state enum.
  - Error-code constants `ERR_LEN`, `ERR_CSUM`, `ERR_TIMEOUT`.
  - Default `HEADER`.
- Sub-module `uart_frame_timeout` is the timeout counter. Inputs: enable, clear. Output: expire pulse, parameterized by `TIMEOUT_CYCLES`.
- Buffer: `MAX_LEN`x8 register array, indexed by a clog2(`MAX_LEN`+1)-bit counter.

## Test plan
- Valid frame A5 10 02 11 22 45 -> writes (0x10,0x11) then (0x11,0x22) on consecutive cycles; `frame_ok` pulse; `err_code` unchanged.
- Address wrap A5 FF 02 AA BB 66 -> writes (0xFF,0xAA), (0x00,0xBB); `frame_ok`.
- Bad checksum A5 10 02 11 22 46 -> no `wr_en`; `frame_err` pulse; `err_code`=10.
- Bad length A5 10 09 -> `frame_err`, `err_code`=01, back in IDLE. A following valid frame commits normally.
- Timeout: A5 10, then silence for `TIMEOUT_CYCLES` -> `frame_err`, `err_code`=11, `busy`=0. Leading garbage 00 37 before a valid frame is ignored.
- `rst_n` asserted during COMMIT of an 8-byte frame -> `wr_en` drops at once, all outputs 0, no `frame_ok`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART command-frame path: FSM states,
// error codes and the default start-of-frame byte.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_LEN    = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_COMMIT = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    // States in which the frame is waiting on the next byte from the line
    function automatic logic waiting_for_byte(input state_e s);
        return (s == ST_ADDR) || (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout counter. Counts enabled cycles since the last clear
// and raises a single-cycle expire pulse when the limit is reached.
module uart_frame_timeout #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd4340
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // A clear on the expiring cycle wins, so a late byte is never lost
    assign expire_o = en_i && !clr_i && (cnt_q == TIMEOUT_CYCLES - 32'd1);

    // Next count: zero while idle or cleared, otherwise advance
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = 32'd0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Command-frame parser behind the UART receiver: HEADER, ADDR, LEN,
// payload, checksum. Payload is buffered and written out one register per
// cycle only after the checksum matches.
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter logic [7:0]  HEADER         = HEADER_DEFAULT,
    parameter int          MAX_LEN        = 8,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd4340
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int             IDXW      = $clog2(MAX_LEN + 1);
    localparam int             AW        = $clog2(MAX_LEN);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

    state_e          state_q, state_d;
    logic [7:0]      base_q, base_d;
    logic [7:0]      sum_q, sum_d;
    logic [IDXW-1:0] len_q, len_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [1:0]      err_q, err_d;
    logic            frame_ok_q, frame_ok_d;
    logic            frame_err_q, frame_err_d;
    logic            rx_done_q;
    logic [7:0]      pay_buf_q [MAX_LEN];

    logic            accept;
    logic            tmo_expire;

    // rx_done is a level; only its rising edge accepts a byte
    assign accept = rx_done && !rx_done_q;

    uart_frame_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (waiting_for_byte(state_q)),
        .clr_i    (accept),
        .expire_o (tmo_expire)
    );

    // Commit writes come straight from state so reset silences them at once
    assign wr_en     = (state_q == ST_COMMIT);
    assign wr_addr   = wr_en ? (base_q + {{(8-IDXW){1'b0}}, idx_q}) : 8'h00;
    assign wr_data   = wr_en ? pay_buf_q[idx_q[AW-1:0]] : 8'h00;
    assign busy      = (state_q != ST_IDLE);
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_q;

    // Frame parsing FSM: next state, field latches, running sum, pulses
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        sum_d       = sum_q;
        len_d       = len_q;
        idx_d       = idx_q;
        err_d       = err_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && rx_data == HEADER) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (accept) begin
                    base_d  = rx_data;
                    sum_d   = rx_data;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                        frame_err_d = 1'b1;
                        err_d       = ERR_LEN;
                        state_d     = ST_IDLE;
                    end else begin
                        len_d   = rx_data[IDXW-1:0];
                        sum_d   = sum_q + rx_data;
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    sum_d = sum_q + rx_data;
                    idx_d = idx_q + IDX_ONE;
                    if (idx_d == len_q) state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (rx_data == sum_q) begin
                        idx_d   = '0;
                        state_d = ST_COMMIT;
                    end else begin
                        frame_err_d = 1'b1;
                        err_d       = ERR_CSUM;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_COMMIT: begin
                idx_d = idx_q + IDX_ONE;
                if (idx_q == len_q - IDX_ONE) begin
                    frame_ok_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Expiry is already masked by an accepted byte in the counter
        if (tmo_expire) begin
            frame_err_d = 1'b1;
            err_d       = ERR_TIMEOUT;
            state_d     = ST_IDLE;
        end
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            base_q      <= 8'h00;
            sum_q       <= 8'h00;
            len_q       <= '0;
            idx_q       <= '0;
            err_q       <= ERR_NONE;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            sum_q       <= sum_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            rx_done_q   <= rx_done;
        end
    end

    // Payload buffer; contents are irrelevant until a full frame lands
    always_ff @(posedge clk) begin
        if (state_q == ST_DATA && accept) begin
            pay_buf_q[idx_q[AW-1:0]] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: directed frames from the test
// plan, timeout, reset during commit, and randomized frames checked against
// a field-level frame model.
module tb_uart_frame_ctrl;

    localparam int MAX_LEN = 8;
    localparam int TMO     = 4340;
    localparam int W       = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    uart_frame_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         last_cyc = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    int         obs_cyc_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] g_q[$];
    logic [7:0] pay [MAX_LEN];
    logic [1:0] model_err;

    // clock / cycle count
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: {kind, code, addr, data}; 1=write, 2=ok, 3=error
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (wr_en) begin
                obs_q.push_back({2'd1, 2'd0, wr_addr, wr_data});
                obs_cyc_q.push_back(cyc);
            end
            if (frame_ok) begin
                obs_q.push_back({2'd2, 2'd0, 16'h0000});
                obs_cyc_q.push_back(cyc);
            end
            if (frame_err) begin
                obs_q.push_back({2'd3, err_code, 16'h0000});
                obs_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] good_csum(input logic [7:0] base, input logic [7:0] len);
        logic [7:0] s;
        s = base + len;
        for (int i = 0; i < int'(len) && i < MAX_LEN; i++) s = s + pay[i];
        return s;
    endfunction

    // Frame model: what a frame built from these fields must produce
    task automatic model_frame(input logic [7:0] base, input logic [7:0] len, input logic [7:0] cs);
        if (len == 8'd0 || int'(len) > MAX_LEN) begin
            exp_q.push_back({2'd3, 2'b01, 16'h0000});
            model_err = 2'b01;
        end else if (cs != good_csum(base, len)) begin
            exp_q.push_back({2'd3, 2'b10, 16'h0000});
            model_err = 2'b10;
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                logic [7:0] a;
                a = base + 8'(i);
                exp_q.push_back({2'd1, 2'd0, a, pay[i]});
            end
            exp_q.push_back({2'd2, 2'd0, 16'h0000});
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_done  = 1'b1;
        last_cyc = cyc;
        @(negedge clk);
        rx_done = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic flush_obs();
        obs_q.delete();
        obs_cyc_q.delete();
    endtask

    task automatic compare_events();
        int n;
        check_eq("evt_count", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            check_eq("evt", obs_q[k], exp_q[k]);
            check_eq("evt_cycle", obs_cyc_q[k], last_cyc + 1 + k);
        end
        check_eq("idle_busy", busy, 1'b0);
        check_eq("err_code_hold", err_code, model_err);
        exp_q.delete();
    endtask

    // Garbage from g_q, then the frame; payload taken from pay[]
    task automatic do_frame(input logic [7:0] base, input logic [7:0] len, input logic [7:0] delta);
        logic [7:0] cs;
        cs = good_csum(base, len) + delta;
        tx_q.delete();
        foreach (g_q[i]) tx_q.push_back(g_q[i]);
        tx_q.push_back(8'hA5);
        tx_q.push_back(base);
        tx_q.push_back(len);
        if (len != 8'd0 && int'(len) <= MAX_LEN) begin
            for (int i = 0; i < int'(len); i++) tx_q.push_back(pay[i]);
            tx_q.push_back(cs);
        end
        model_frame(base, len, cs);
        flush_obs();
        foreach (tx_q[i]) send_byte(tx_q[i], $urandom_range(0, 4));
        repeat (14) @(negedge clk);
        compare_events();
        g_q.delete();
    endtask

    initial begin
        int   elapsed;
        logic seen;
        logic [7:0] len;
        logic [7:0] delta;
        logic [7:0] b;
        int   r;

        rst_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00; model_err = 2'b00;
        repeat (3) @(negedge clk);
        check_eq("rst_wr_en", wr_en, 1'b0);
        check_eq("rst_wr_addr", wr_addr, 8'h00);
        check_eq("rst_wr_data", wr_data, 8'h00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_frame_ok", frame_ok, 1'b0);
        check_eq("rst_frame_err", frame_err, 1'b0);
        check_eq("rst_err_code", err_code, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);

        // directed frames
        pay[0] = 8'h11; pay[1] = 8'h22;
        do_frame(8'h10, 8'd2, 8'd0);
        pay[0] = 8'hAA; pay[1] = 8'hBB;
        do_frame(8'hFF, 8'd2, 8'd0);
        pay[0] = 8'h11; pay[1] = 8'h22;
        do_frame(8'h10, 8'd2, 8'd1);
        do_frame(8'h10, 8'd9, 8'd0);
        do_frame(8'h10, 8'd2, 8'd0);

        // timeout after A5 10
        flush_obs();
        send_byte(8'hA5, 0);
        send_byte(8'h10, 0);
        check_eq("tmo_busy_wait", busy, 1'b1);
        elapsed = 0;
        seen = 1'b0;
        for (int i = 0; i < TMO + 100 && !seen; i++) begin
            @(negedge clk);
            if (frame_err) begin
                seen = 1'b1;
                elapsed = cyc - last_cyc;
            end
        end
        check_eq("tmo_seen", seen, 1'b1);
        check_eq("tmo_window", (elapsed >= TMO && elapsed <= TMO + 2), 1'b1);
        check_eq("tmo_err_code", err_code, 2'b11);
        check_eq("tmo_busy", busy, 1'b0);
        model_err = 2'b11;
        repeat (2) @(negedge clk);
        flush_obs();

        // leading garbage then a valid frame
        g_q.push_back(8'h00); g_q.push_back(8'h37);
        pay[0] = 8'h11; pay[1] = 8'h22;
        do_frame(8'h10, 8'd2, 8'd0);

        // randomized frames
        for (int e = 0; e < 40; e++) begin
            r = $urandom_range(0, 2);
            for (int g = 0; g < r; g++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h00;
                g_q.push_back(b);
            end
            for (int i = 0; i < MAX_LEN; i++) pay[i] = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 9);
            if (r < 8)       len = 8'(r + 1);
            else if (r == 8) len = 8'd0;
            else             len = 8'($urandom_range(9, 255));
            delta = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            do_frame(8'($urandom_range(0, 255)), len, delta);
        end

        // reset in the middle of an 8-byte commit
        for (int i = 0; i < MAX_LEN; i++) pay[i] = 8'($urandom_range(0, 255));
        send_byte(8'hA5, 1);
        send_byte(8'h40, 1);
        send_byte(8'd8, 1);
        for (int i = 0; i < MAX_LEN; i++) send_byte(pay[i], 1);
        send_byte(good_csum(8'h40, 8'd8), 0);
        repeat (2) @(negedge clk);
        check_eq("rst_commit_active", wr_en, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("rstc_wr_en", wr_en, 1'b0);
        check_eq("rstc_wr_addr", wr_addr, 8'h00);
        check_eq("rstc_wr_data", wr_data, 8'h00);
        check_eq("rstc_busy", busy, 1'b0);
        check_eq("rstc_frame_ok", frame_ok, 1'b0);
        check_eq("rstc_frame_err", frame_err, 1'b0);
        check_eq("rstc_err_code", err_code, 2'b00);
        model_err = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        flush_obs();
        repeat (12) @(negedge clk);
        check_eq("rstc_no_events", obs_q.size(), 0);

        // recovery frame after reset
        pay[0] = 8'h5A; pay[1] = 8'hC3; pay[2] = 8'h01;
        do_frame(8'hFE, 8'd3, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
